store_buffer: RTL

Four-entry in-order FIFO of retired stores, placed directly upstream of `data_memory_top` in stage 4. Stores are accepted from the pipeline in one cycle and written to data memory in idle cycles, when the single memory port carries no load. Loads get the port first. A load whose word address matches a pending store is stalled until that store has drained, so a load never returns stale data.

---
 rtl/store_buffer.sv | 75 +++++++
 1 files changed

// File: rtl/store_buffer.sv
// store_buffer: in-order retired-store FIFO sharing the data memory port with loads.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       st_valid,
    input  logic [31:0]                st_addr,
    input  logic [31:0]                st_data,
    input  logic [2:0]                 st_type,
    output logic                       st_ready,
    input  logic                       ld_valid,
    input  logic [31:0]                ld_addr,
    output logic                       ld_stall,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [31:0]                mem_addr,
    output logic [31:0]                mem_write_value,
    output logic [2:0]                 mem_load_type,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [2:0]    type_q [DEPTH];
    logic [PW-1:0] head, tail, off;
    logic          full, hit, load_go, drain_go, enq;

    always_comb begin
        off = '0;
        hit = st_valid && (st_addr[31:2] == ld_addr[31:2]);
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - head;
            if ((CW'(off) < count) && (addr_q[i][31:2] == ld_addr[31:2])) hit = 1'b1;
        end
    end

    always_comb begin
        full            = (count == CW'(DEPTH));
        empty           = (count == '0);
        st_ready        = !full;
        enq             = st_valid && st_ready;
        ld_stall        = ld_valid && (hit || full);
        load_go         = ld_valid && !ld_stall;
        drain_go        = !empty && !load_go;
        mem_read        = load_go;
        mem_write       = drain_go;
        mem_addr        = load_go ? ld_addr : drain_go ? addr_q[head] : '0;
        mem_write_value = drain_go ? data_q[head] : '0;
        mem_load_type   = drain_go ? type_q[head] : '0;
    end

    always_ff @(posedge clock) begin
        if (enq) begin
            addr_q[tail] <= st_addr;
            data_q[tail] <= st_data;
            type_q[tail] <= st_type;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= tail + 1'b1;
            if (drain_go) head <= head + 1'b1;
            count <= count + CW'(enq) - CW'(drain_go);
        end
    end
endmodule
